// File: rtl/gpu_cmd_scheduler_if.sv
// gpu_cmd_scheduler_if
// Bundles the host byte stream, the pixel-sink handshake and the scheduler
// outputs into one connection.
//   master : the host/system side. Drives host_valid, host_data and vram_ready.
//            Observes every scheduler output.
//   slave  : the scheduler itself.
//   host_valid/host_data/host_ready : byte stream handshake
//   vram_ready                      : pixel sink can take a write
//   cfg_en/cfg_data                 : one-cycle config write strobe + byte
//   pix_wr_en/pix_addr/pix_data     : one-cycle pixel write strobe + addr/data
//   busy/err                        : status (not idle / sticky error)
`timescale 1ns/1ps

interface gpu_cmd_scheduler_if;
  logic        host_valid;
  logic [7:0]  host_data;
  logic        host_ready;
  logic        vram_ready;
  logic        cfg_en;
  logic [7:0]  cfg_data;
  logic        pix_wr_en;
  logic [15:0] pix_addr;
  logic [7:0]  pix_data;
  logic        busy;
  logic        err;

  modport master (
    output host_valid, host_data, vram_ready,
    input  host_ready, cfg_en, cfg_data, pix_wr_en, pix_addr, pix_data,
           busy, err
  );

  modport slave (
    input  host_valid, host_data, vram_ready,
    output host_ready, cfg_en, cfg_data, pix_wr_en, pix_addr, pix_data,
           busy, err
  );
endinterface

// File: rtl/gpu_cmd_scheduler.sv
// gpu_cmd_scheduler
// Decodes a host byte stream into config writes, address loads and pixel
// bursts. Stalled commands are aborted after TIMEOUT idle cycles.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : gpu_cmd_scheduler_if.slave (host stream, pixel sink, status)
// Opcodes in IDLE:
//   0xxx_xxxx config write
//   0x80      set address (hi, lo)
//   0x81      pixel burst (count, data...)
//   0xFE      clear err
//   0xFF      NOP
//   other 1xxx_xxxx sets err
`timescale 1ns/1ps

module gpu_cmd_scheduler #(
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  gpu_cmd_scheduler_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR_HI = 3'd1;
  localparam logic [2:0] ST_ADDR_LO = 3'd2;
  localparam logic [2:0] ST_COUNT   = 3'd3;
  localparam logic [2:0] ST_DATA    = 3'd4;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  // addr_q is the next write address; pix_addr_q is the presented address.
  logic [15:0] addr_q, addr_d;
  logic [8:0]  remain_q, remain_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        cfg_en_q, cfg_en_d;
  logic [7:0]  cfg_data_q, cfg_data_d;
  logic        pix_wr_en_q, pix_wr_en_d;
  logic [15:0] pix_addr_q, pix_addr_d;
  logic [7:0]  pix_data_q, pix_data_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        host_ready;
  logic        accept;
  logic [7:0]  host_byte;
  logic [15:0] to_inc;

  // Only a pixel burst can be backpressured by the sink.
  assign host_ready = (state_q == ST_DATA) ? bus.vram_ready : 1'b1;
  assign accept     = bus.host_valid & host_ready;
  assign host_byte  = bus.host_data;
  assign to_inc     = to_cnt_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    addr_hi_d   = addr_hi_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    to_cnt_d    = 16'd0;
    cfg_en_d    = 1'b0;
    cfg_data_d  = cfg_data_q;
    pix_wr_en_d = 1'b0;
    pix_data_d  = pix_data_q;
    err_d       = err_q;

    // Timeout supervision. An accepted byte always restarts the count, so an
    // acceptance in the expiry cycle wins over the abort.
    if (state_q != ST_IDLE) begin
      if (accept) begin
        to_cnt_d = 16'd0;
      end else if (to_inc == TO_LIMIT) begin
        state_d  = ST_IDLE;
        err_d    = 1'b1;
        to_cnt_d = 16'd0;
      end else begin
        to_cnt_d = to_inc;
      end
    end

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (!host_byte[7]) begin
            cfg_en_d   = 1'b1;
            cfg_data_d = host_byte;
          end else begin
            case (host_byte)
              8'h80:   state_d = ST_ADDR_HI;
              8'h81:   state_d = ST_COUNT;
              8'hFE:   err_d   = 1'b0;
              8'hFF:   ;
              default: err_d   = 1'b1;
            endcase
          end
        end
        ST_ADDR_HI: begin
          addr_hi_d = host_byte;
          state_d   = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_d  = {addr_hi_q, host_byte};
          state_d = ST_IDLE;
        end
        ST_COUNT: begin
          // A count of zero encodes a full 256-byte burst.
          remain_d = (host_byte == 8'h00) ? 9'd256 : {1'b0, host_byte};
          state_d  = ST_DATA;
        end
        ST_DATA: begin
          pix_wr_en_d = 1'b1;
          pix_data_d  = host_byte;
          addr_d      = addr_q + 16'd1;
          remain_d    = remain_q - 9'd1;
          if (remain_q == 9'd1) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // During a write strobe present the address being written; otherwise
    // present the (possibly just updated) next address.
    pix_addr_d = pix_wr_en_d ? addr_q : addr_d;
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_hi_q   <= 8'h00;
      addr_q      <= 16'h0000;
      remain_q    <= 9'd0;
      to_cnt_q    <= 16'd0;
      cfg_en_q    <= 1'b0;
      cfg_data_q  <= 8'h00;
      pix_wr_en_q <= 1'b0;
      pix_addr_q  <= 16'h0000;
      pix_data_q  <= 8'h00;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_hi_q   <= addr_hi_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      to_cnt_q    <= to_cnt_d;
      cfg_en_q    <= cfg_en_d;
      cfg_data_q  <= cfg_data_d;
      pix_wr_en_q <= pix_wr_en_d;
      pix_addr_q  <= pix_addr_d;
      pix_data_q  <= pix_data_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign bus.host_ready = host_ready;
  assign bus.cfg_en     = cfg_en_q;
  assign bus.cfg_data   = cfg_data_q;
  assign bus.pix_wr_en  = pix_wr_en_q;
  assign bus.pix_addr   = pix_addr_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_gpu_cmd_scheduler.sv
// tb_gpu_cmd_scheduler
// Directed bench for gpu_cmd_scheduler with a short TIMEOUT. Inputs change at
// the falling edge or 1ns after the rising edge. Outputs are read 1ns after the
// rising edge, and a falling-edge monitor logs every strobe.
`timescale 1ns/1ps

module tb_gpu_cmd_scheduler;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;

  gpu_cmd_scheduler_if bus();

  gpu_cmd_scheduler #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [23:0] wr_log[$];
  int          cfg_count = 0;
  logic        both_seen = 1'b0;

  // Record every pixel write as {addr, data} and watch strobe exclusivity.
  always @(negedge clk) begin
    if (bus.pix_wr_en) wr_log.push_back({bus.pix_addr, bus.pix_data});
    if (bus.cfg_en) cfg_count++;
    if (bus.cfg_en && bus.pix_wr_en) both_seen = 1'b1;
  end

  // Present one byte and hold it until accepted. Returns 1ns after the
  // accepting edge with host_valid dropped.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    @(negedge clk);
    bus.host_valid = 1'b1;
    bus.host_data  = b;
    waited = 0;
    while (!bus.host_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.host_ready) begin
      total++; bad++;
      $display("[TB] FAIL send_byte_%02h: host_ready=%b required 1 within 50 cycles", b, bus.host_ready);
      bus.host_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.host_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_data  = 8'h80;
    bus.vram_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.cfg_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_cfg_en: got %b want 0", bus.cfg_en); end
    total++; if (bus.cfg_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_cfg_data: got %h want 00", bus.cfg_data); end
    total++; if (bus.pix_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_pix_wr_en: got %b want 0", bus.pix_wr_en); end
    total++; if (bus.pix_addr !== 16'h0000) begin bad++; $display("[TB] FAIL reset_pix_addr: got %h want 0000", bus.pix_addr); end
    total++; if (bus.pix_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_pix_data: got %h want 00", bus.pix_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.err); end
    total++; if (bus.host_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_host_ready: got %b want 1", bus.host_ready); end
    rst            = 1'b0;
    bus.host_valid = 1'b0;
    @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_priority_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_config();
    cfg_count = 0;
    send_byte(8'h5A);
    total++; if (bus.cfg_en !== 1'b1) begin bad++; $display("[TB] FAIL cfg_en_pulse: got %b want 1", bus.cfg_en); end
    total++; if (bus.cfg_data !== 8'h5A) begin bad++; $display("[TB] FAIL cfg_data: got %h want 5a", bus.cfg_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL cfg_busy: got %b want 0", bus.busy); end
    total++; if (bus.pix_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL cfg_pix_wr_en: got %b want 0", bus.pix_wr_en); end
    @(posedge clk);
    #1;
    total++; if (bus.cfg_en !== 1'b0) begin bad++; $display("[TB] FAIL cfg_en_single: got %b want 0", bus.cfg_en); end
    total++; if (cfg_count !== 1) begin bad++; $display("[TB] FAIL cfg_count: got %0d want 1", cfg_count); end
  endtask

  task automatic test_burst();
    logic [23:0] exp_w [3] = '{24'h1234AA, 24'h1235BB, 24'h1236CC};
    wr_log.delete();
    send_byte(8'h80); send_byte(8'h12); send_byte(8'h34);
    total++; if (bus.pix_addr !== 16'h1234) begin bad++; $display("[TB] FAIL burst_addr_load: got %h want 1234", bus.pix_addr); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL burst_addr_idle: got %b want 0", bus.busy); end
    send_byte(8'h81);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL burst_busy: got %b want 1", bus.busy); end
    send_byte(8'h03); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    total++; if (bus.pix_addr !== 16'h1236) begin bad++; $display("[TB] FAIL burst_last_addr: got %h want 1236", bus.pix_addr); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL burst_end_busy: got %b want 0", bus.busy); end
    @(posedge clk);
    #1;
    total++; if (bus.pix_addr !== 16'h1237) begin bad++; $display("[TB] FAIL burst_final_addr: got %h want 1237", bus.pix_addr); end
    total++; if (wr_log.size() !== 3) begin bad++; $display("[TB] FAIL burst_count: got %0d want 3", wr_log.size()); end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      total++; if (wr_log[i] !== exp_w[i]) begin bad++; $display("[TB] FAIL burst_write_%0d: got %h want %h", i, wr_log[i], exp_w[i]); end
    end
  endtask

  task automatic test_back_to_back_backpressure();
    logic [23:0] exp_w [3] = '{24'h200011, 24'h200122, 24'h200233};
    wr_log.delete();
    send_byte(8'h80); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'h81); send_byte(8'h03); send_byte(8'h11);
    @(negedge clk);
    bus.vram_ready = 1'b0;
    bus.host_valid = 1'b1;
    bus.host_data  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++; if (bus.host_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_host_ready_%0d: got %b want 0", i, bus.host_ready); end
      total++; if (bus.pix_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL bp_no_strobe_%0d: got %b want 0", i, bus.pix_wr_en); end
    end
    bus.vram_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.host_valid = 1'b0;
    total++; if (bus.pix_wr_en !== 1'b1 || bus.pix_data !== 8'h22 || bus.pix_addr !== 16'h2001) begin
      bad++; $display("[TB] FAIL bp_resume: got en=%b addr=%h data=%h want en=1 addr=2001 data=22", bus.pix_wr_en, bus.pix_addr, bus.pix_data);
    end
    send_byte(8'h33);
    @(posedge clk);
    #1;
    total++; if (wr_log.size() !== 3) begin bad++; $display("[TB] FAIL bp_count: got %0d want 3", wr_log.size()); end
    for (int i = 0; i < 3 && i < wr_log.size(); i++) begin
      total++; if (wr_log[i] !== exp_w[i]) begin bad++; $display("[TB] FAIL bp_write_%0d: got %h want %h", i, wr_log[i], exp_w[i]); end
    end
  endtask

  task automatic test_wrap();
    logic [23:0] exp_w [2] = '{24'hFFFF01, 24'h000002};
    wr_log.delete();
    send_byte(8'h80); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h81); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02);
    @(posedge clk);
    #1;
    total++; if (bus.pix_addr !== 16'h0001) begin bad++; $display("[TB] FAIL wrap_final_addr: got %h want 0001", bus.pix_addr); end
    total++; if (wr_log.size() !== 2) begin bad++; $display("[TB] FAIL wrap_count: got %0d want 2", wr_log.size()); end
    for (int i = 0; i < 2 && i < wr_log.size(); i++) begin
      total++; if (wr_log[i] !== exp_w[i]) begin bad++; $display("[TB] FAIL wrap_write_%0d: got %h want %h", i, wr_log[i], exp_w[i]); end
    end
  endtask

  task automatic test_errors();
    wr_log.delete();
    send_byte(8'h90);
    total++; if (bus.err !== 1'b1) begin bad++; $display("[TB] FAIL illegal_err: got %b want 1", bus.err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL illegal_busy: got %b want 0", bus.busy); end
    total++; if (bus.cfg_en !== 1'b0) begin bad++; $display("[TB] FAIL illegal_cfg_en: got %b want 0", bus.cfg_en); end
    send_byte(8'hFF);
    total++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL nop: got err=%b busy=%b want err=1 busy=0", bus.err, bus.busy); end
    send_byte(8'hFE);
    total++; if (bus.err !== 1'b0) begin bad++; $display("[TB] FAIL clear_err: got %b want 0", bus.err); end
    send_byte(8'h81); send_byte(8'h02);
    repeat (TO - 1) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin bad++; $display("[TB] FAIL timeout_early: got busy=%b err=%b want busy=1 err=0", bus.busy, bus.err); end
    @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL timeout_busy: got %b want 0", bus.busy); end
    total++; if (bus.err !== 1'b1) begin bad++; $display("[TB] FAIL timeout_err: got %b want 1", bus.err); end
    total++; if (bus.pix_addr !== 16'h0001) begin bad++; $display("[TB] FAIL timeout_addr_kept: got %h want 0001", bus.pix_addr); end
    total++; if (wr_log.size() !== 0) begin bad++; $display("[TB] FAIL timeout_writes: got %0d want 0", wr_log.size()); end
    send_byte(8'h05);
    total++; if (bus.cfg_en !== 1'b1 || bus.cfg_data !== 8'h05) begin bad++; $display("[TB] FAIL timeout_back_idle: got en=%b data=%h want en=1 data=05", bus.cfg_en, bus.cfg_data); end
  endtask

  task automatic test_reset_mid_burst();
    wr_log.delete();
    send_byte(8'h80); send_byte(8'h40); send_byte(8'h00);
    send_byte(8'h81); send_byte(8'h04); send_byte(8'h77);
    @(negedge clk);
    rst            = 1'b1;
    bus.host_valid = 1'b1;
    bus.host_data  = 8'h88;
    @(posedge clk);
    #1;
    total++; if (bus.cfg_en !== 1'b0 || bus.cfg_data !== 8'h00) begin bad++; $display("[TB] FAIL rmid_cfg: got en=%b data=%h want 0/00", bus.cfg_en, bus.cfg_data); end
    total++; if (bus.pix_wr_en !== 1'b0 || bus.pix_addr !== 16'h0000 || bus.pix_data !== 8'h00) begin
      bad++; $display("[TB] FAIL rmid_pix: got en=%b addr=%h data=%h want 0/0000/00", bus.pix_wr_en, bus.pix_addr, bus.pix_data);
    end
    total++; if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("[TB] FAIL rmid_status: got busy=%b err=%b want 0/0", bus.busy, bus.err); end
    rst            = 1'b0;
    bus.host_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++; if (wr_log.size() !== 1) begin bad++; $display("[TB] FAIL rmid_count: got %0d want 1", wr_log.size()); end
    if (wr_log.size() > 0) begin
      total++; if (wr_log[0] !== 24'h400077) begin bad++; $display("[TB] FAIL rmid_write: got %h want 400077", wr_log[0]); end
    end
    send_byte(8'h5B);
    total++; if (bus.cfg_en !== 1'b1 || bus.cfg_data !== 8'h5B) begin bad++; $display("[TB] FAIL rmid_idle: got en=%b data=%h want 1/5b", bus.cfg_en, bus.cfg_data); end
  endtask

  task automatic test_exclusive();
    total++; if (both_seen !== 1'b0) begin bad++; $display("[TB] FAIL strobe_exclusive: got %b want 0", both_seen); end
  endtask

  initial begin
    bus.host_valid = 1'b0;
    bus.host_data  = 8'h00;
    bus.vram_ready = 1'b1;
    rst            = 1'b1;
    test_reset();
    test_config();
    test_burst();
    test_back_to_back_backpressure();
    test_wrap();
    test_errors();
    test_reset_mid_burst();
    test_exclusive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
